// File: rtl/i281_code_loader.sv
// Reloadable code memory for the i281 CPU: a byte-stream loader assembles
// big-endian instruction words, verifies a trailing checksum, and stalls the CPU meanwhile.
module i281_code_loader #(
  parameter int WORDS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_error,
  output logic          cpu_hold,
  output logic [AW:0]   word_count,
  input  logic [AW-1:0] fetch_addr,
  output logic [15:0]   fetch_instr
);

  typedef enum logic [2:0] {IDLE, RX_HI, RX_LO, CHECK, ERROR} state_t;

  state_t        state;
  logic [15:0]   mem [WORDS];
  logic [AW-1:0] ptr;
  logic [7:0]    hi_reg;
  logic [7:0]    acc;
  logic          accept;

  assign accept = byte_valid && byte_ready;

  // load_start outranks a simultaneous byte so a restart always begins from a clean stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      ptr        <= '0;
      acc        <= '0;
      hi_reg     <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state      <= RX_HI;
        ptr        <= '0;
        acc        <= '0;
        word_count <= '0;
      end else if (accept) begin
        case (state)
          RX_HI: begin
            hi_reg <= byte_data;
            acc    <= acc + byte_data;
            state  <= RX_LO;
          end
          RX_LO: begin
            mem[ptr]   <= {hi_reg, byte_data};
            acc        <= acc + byte_data;
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
            state      <= (ptr == AW'(WORDS - 1)) ? CHECK : RX_HI;
          end
          CHECK: begin
            if (8'(acc + byte_data) == 8'h00) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end else begin
              state <= ERROR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready  = (state == RX_HI) || (state == RX_LO) || (state == CHECK);
  assign load_busy   = byte_ready;
  assign load_error  = (state == ERROR);
  assign cpu_hold    = load_busy | load_error;
  // A held CPU sees NOOPs so a half-written program can never execute.
  assign fetch_instr = cpu_hold ? 16'h0000 : mem[fetch_addr];

endmodule

// File: tb/tb_i281_code_loader.sv
// Scoreboard bench for i281_code_loader: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_i281_code_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic        cpu_hold;
  logic [4:0]  word_count;
  logic [3:0]  fetch_addr;
  logic [15:0] fetch_instr;

  always #5 clk = ~clk;

  i281_code_loader #(.WORDS(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .cpu_hold(cpu_hold), .word_count(word_count),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr)
  );

  // kind 0 = fetch_instr, 1 = word_count, 2 = {byte_ready,busy,done,error,hold}
  typedef struct {string name; int kind; logic [15:0] exp;} probe_t;
  typedef struct {string name; logic good; logic [4:0] wc;} done_t;

  probe_t      probe_q[$];
  done_t       done_q[$];
  probe_t      mp;
  done_t       md;
  int          checks = 0;
  int          passed = 0;
  logic        err_prev = 1'b0;
  logic [15:0] prog  [16];
  logic [15:0] prog2 [16];

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      mp = probe_q.pop_front();
      case (mp.kind)
        0:       check(mp.name, fetch_instr, mp.exp);
        1:       check(mp.name, 16'(word_count), mp.exp);
        default: check(mp.name, 16'({byte_ready, load_busy, load_done, load_error, cpu_hold}), mp.exp);
      endcase
    end
    if (load_done || (load_error && !err_prev)) begin
      if (done_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL completion: got done=%0b error=%0b expected no completion", load_done, load_error);
      end else begin
        md = done_q.pop_front();
        check({md.name, "_ok"}, 16'(load_done), 16'(md.good));
        check({md.name, "_wc"}, 16'(word_count), 16'(md.wc));
      end
    end
    err_prev = load_error;
  end

  task automatic expect_now(string name, int kind, logic [15:0] exp);
    probe_t p;
    p.name = name; p.kind = kind; p.exp = exp;
    probe_q.push_back(p);
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    r = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    byte_valid = 1'b0;
    if (!r) begin
      checks++;
      $display("[TB] FAIL byte_accept_timeout: got byte_ready=0 expected 1 within 50 cycles");
    end
  endtask

  function automatic logic [15:0] img_word(int sel, int i);
    return (sel == 1) ? prog[i] : prog2[i];
  endfunction

  // Sends nbytes of image sel; a full 32-byte stream is followed by its checksum (+adj).
  task automatic send_stream(string name, int sel, int nbytes, int adj, int maxgap);
    logic [7:0] sum;
    logic [7:0] b;
    done_t      d;
    sum = 8'h00;
    for (int k = 0; k < nbytes; k++) begin
      b = (k % 2 == 0) ? img_word(sel, k / 2)[15:8] : img_word(sel, k / 2)[7:0];
      sum = sum + b;
      send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    if (nbytes == 32) begin
      d.name = name; d.good = (adj == 0); d.wc = 5'd16;
      done_q.push_back(d);
      send_byte(8'(8'h00 - sum + 8'(adj)), 0);
    end
  endtask

  task automatic sweep(string tag, int sel, int n);
    for (int i = 0; i < n; i++) begin
      fetch_addr = 4'(i);
      expect_now($sformatf("%s_fetch%0d", tag, i), 0, (sel == 0) ? 16'h0000 : img_word(sel, i));
      step();
    end
  endtask

  initial begin
    prog[0] = 16'hD300;
    prog[1] = 16'hF104;
    for (int i = 2; i < 16; i++) prog[i] = 16'(i * 16'h1357 + 16'h0240);
    for (int i = 0; i < 16; i++) prog2[i] = 16'(i * 16'h0123 + 16'h5A0C);

    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; fetch_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    expect_now("reset_status", 2, 16'h0000);
    expect_now("reset_wc", 1, 16'd0);
    step();
    sweep("reset", 0, 16);

    // good load
    pulse_start();
    expect_now("start_status", 2, 16'b11001);
    fetch_addr = 4'd0;
    expect_now("held_fetch", 0, 16'h0000);
    send_stream("good", 1, 32, 0, 0);
    expect_now("done_status", 2, 16'b00100);
    expect_now("done_wc", 1, 16'd16);
    fetch_addr = 4'd0;
    expect_now("done_fetch0", 0, 16'hD300);
    step();
    expect_now("after_done_status", 2, 16'h0000);
    fetch_addr = 4'd1;
    expect_now("done_fetch1", 0, 16'hF104);
    step();
    sweep("good", 1, 16);

    // bad checksum
    pulse_start();
    send_stream("bad", 1, 32, 1, 0);
    expect_now("err_status", 2, 16'b00011);
    fetch_addr = 4'd1;
    expect_now("err_fetch", 0, 16'h0000);
    step();
    step();
    expect_now("err_persist", 2, 16'b00011);
    step();
    pulse_start();
    expect_now("err_cleared", 2, 16'b11001);

    // partial then restart
    send_stream("part", 2, 7, 0, 0);
    expect_now("part_wc", 1, 16'd3);
    step();
    pulse_start();
    expect_now("restart_wc", 1, 16'd0);
    expect_now("restart_status", 2, 16'b11001);
    send_stream("restart", 2, 32, 0, 0);
    step();
    sweep("restart", 2, 3);

    // gappy load must land the same image as the gap-free one
    pulse_start();
    send_stream("gaps", 1, 32, 0, 5);
    step();
    sweep("gaps", 1, 16);

    // reset in the middle of word 9
    pulse_start();
    send_stream("midreset", 2, 19, 0, 0);
    expect_now("mid_status", 2, 16'b11001);
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_now("mid_reset_status", 2, 16'h0000);
    expect_now("mid_reset_wc", 1, 16'd0);
    step();
    sweep("mid_reset", 0, 16);

    repeat (3) step();
    while (done_q.size() > 0) begin
      md = done_q.pop_front();
      checks++;
      $display("[TB] FAIL %s_missing: got no completion expected load_done=%0b", md.name, md.good);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
